mic_adc_capture: RTL and testbench
==================================

# mic_adc_capture

Front-end capture stage feeding the audio recorder: paces the sample rate, drives a 12-bit serial ADC (ADCS7476-style, 16-SCLK frame) and publishes each sample with a one-cycle `aud_rdy` strobe. `aud_rdy` connects directly to the recorder's `aud_rdy`, and `sample` goes to the memory write-data path. The ADC protocol runs entirely from the system clock, with no second clock domain.

## Interface

- `CLK_DIV`, default 4: clk cycles per SCLK half-period (≥1); 100 MHz clk gives 12.5 MHz SCLK.
- `SAMPLE_DIV`, default 2268: clk cycles per sample period (~44.1 kHz at 100 MHz). Must be ≥ 32*CLK_DIV+3, otherwise overruns occur.

- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: capture enable; same enable that gates the recorder.
- `adc_sdata` in 1: ADC serial data, MSB first, changes after SCLK falling edge.
- `adc_cs_n` out 1: ADC chip select, active low.
- `adc_sclk` out 1: ADC serial clock; idles high.
- `sample` out 12: last captured sample; held between strobes.
- `aud_rdy` out 1: one-cycle pulse; `sample` is valid in that cycle and afterwards.
- `busy` out 1: high while a frame is in progress (CONV or DONE).
- `overrun` out 1: sticky; a sample tick arrived while a frame was still in progress.

## Operation

- **Reset values:** `adc_cs_n`=1, `adc_sclk`=1, `sample`=0, `aud_rdy`=0, `busy`=0, `overrun`=0. All internal counters are 0 and the state is IDLE.
- **Sample timer:** counts 0..SAMPLE_DIV-1 while `en`=1. When `en`=0 it is cleared and held at 0.
  - A tick occurs in the cycle where count==SAMPLE_DIV-1 and `en`=1.
- **FSM states:** IDLE, CONV, DONE.
  - IDLE, tick → CONV. Load the half-period counter and bit counter=0.
  - CONV: `adc_cs_n`=0. `adc_sclk` toggles each time the half-period counter reaches CLK_DIV-1, giving 16 falling/rising pairs, falling first.
  - On the clk edge that drives `adc_sclk` high, shift `adc_sdata` into a 16-bit shift register (LSB in) and increment the bit counter.
  - After the 16th rising edge → DONE.
  - DONE (one cycle): `adc_cs_n`=1, `sample`<=shift[11:0], `aud_rdy`=1 → IDLE.
  - Bits [15:12] (leading zeros) are discarded and not checked.
- **`busy`** is 1 in CONV and DONE.
- **Overrun:** a tick while the state ≠ IDLE is dropped (no queued frame) and sets `overrun`. `overrun` clears only on `rst` or while `en`=0.
- **`en` falling mid-frame:** the frame completes normally, including `aud_rdy` and the `sample` update. No new tick occurs until `en` returns.
- **`rst` mid-frame:** outputs go to reset values immediately. `adc_cs_n` rises asynchronously and the partial frame is discarded.
- **Counter widths:** `$clog2` of the respective divider. The bit counter is 5 bits and saturates at 16.

## Timing

- Tick at cycle T: `adc_cs_n` low from T+1.
- SCLK falling edge k (k=1..16) at T+1+(2k-1)*CLK_DIV.
- SCLK rising edge k at T+1+2k*CLK_DIV. `adc_sdata` is sampled at that edge.
- DONE / `aud_rdy` at T+2+32*CLK_DIV. `adc_cs_n` and `adc_sclk` are both high from that cycle.
- Latency from tick to `aud_rdy` is 32*CLK_DIV+2 cycles. `sample` updates in the same cycle `aud_rdy` is 1.
- First tick after `en` rises (sampled high at cycle E): cycle E+SAMPLE_DIV-1. Subsequent ticks every SAMPLE_DIV cycles.
- `aud_rdy` is never high in two consecutive cycles.
- All outputs are registered, with no combinational paths from inputs.

## Test plan

- **Basic capture.** CLK_DIV=2, SAMPLE_DIV=80, ADC model returns 16'h0ABC.
  - Required: `aud_rdy` 66 cycles after each tick; `sample`=12'hABC; exactly 16 SCLK rises with `adc_cs_n` low.
- **Steady rate.** Same parameters, `en` held high for 800 cycles with data 12'h001, 12'hFFF, 12'h800 ...
  - Required: `aud_rdy` pulses exactly 80 cycles apart; samples match in order; `overrun`=0.
- **Overrun.** CLK_DIV=2, SAMPLE_DIV=40.
  - Required: `overrun`=1 after the second tick; every other tick is dropped, so `aud_rdy` spacing is 80; `overrun` clears when `en`=0.
- **`en` dropped mid-frame.** Drop `en` 10 cycles after `adc_cs_n` falls.
  - Required: frame completes, one `aud_rdy`, then no further `adc_cs_n` activity for 500 cycles.
- **Async reset mid-frame.** Assert `rst` between clock edges during CONV.
  - Required: `adc_cs_n`=1, `adc_sclk`=1, `sample`=0 before the next clk edge; after release with `en`=1, first tick at SAMPLE_DIV-1.
- **Recorder integration.** Connect to the recorder with track 1 initialised; run 5 samples.
  - Required: recorder address advances by 5 with 5 `write_en` pulses, each coinciding with the `aud_rdy`-to-write sequence.

Source files
------------

// File: rtl/mic_adc_capture.sv
// Sample-rate pacer and 16-SCLK serial ADC reader for the audio recorder.
// Publishes each 12-bit sample with a one-cycle aud_rdy strobe.
module mic_adc_capture #(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 2268
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        adc_sdata,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [11:0] sample,
  output logic        aud_rdy,
  output logic        busy,
  output logic        overrun
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_DIV - 1);

  logic [1:0]    state;
  logic [TW-1:0] tcnt;
  logic [HW-1:0] hcnt;
  logic [4:0]    bcnt;
  logic [11:0]   shift;
  logic          tick;

  assign tick = en && (tcnt == T_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (!en || tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // A tick that lands mid-frame is dropped, never queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (!en) begin
      overrun <= 1'b0;
    end else if (tick && state != IDLE) begin
      overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hcnt     <= '0;
      bcnt     <= '0;
      shift    <= '0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b1;
      sample   <= '0;
      aud_rdy  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          aud_rdy <= 1'b0;
          if (tick) begin
            state    <= CONV;
            hcnt     <= '0;
            bcnt     <= '0;
            adc_cs_n <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CONV: begin
          if (bcnt == 5'd16) begin
            state    <= DONE;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
            sample   <= shift;
            aud_rdy  <= 1'b1;
          end else if (hcnt == H_LAST) begin
            hcnt     <= '0;
            adc_sclk <= ~adc_sclk;
            // Data is captured on the edge that raises SCLK.
            if (!adc_sclk) begin
              shift <= {shift[10:0], adc_sdata};
              bcnt  <= bcnt + 5'd1;
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          aud_rdy <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b1;
          aud_rdy  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mic_adc_capture.sv
// Bench for mic_adc_capture: ADC models, table vectors, random en
// intervals against a timing model, and hand-written corner cases.
module tb_mic_adc_capture;

  localparam int CD  = 2;
  localparam int SDA = 80;
  localparam int SDB = 40;
  localparam int LAT = 32 * CD + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0, en_b = 1'b0;
  logic sdata_a = 1'b0, sdata_b = 1'b0;
  logic cs_n_a, sclk_a, aud_rdy_a, busy_a, overrun_a;
  logic cs_n_b, sclk_b, aud_rdy_b, busy_b, overrun_b;
  logic [11:0] sample_a, sample_b;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mic_adc_capture #(.CLK_DIV(CD), .SAMPLE_DIV(SDA)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .adc_sdata(sdata_a),
    .adc_cs_n(cs_n_a), .adc_sclk(sclk_a), .sample(sample_a),
    .aud_rdy(aud_rdy_a), .busy(busy_a), .overrun(overrun_a)
  );

  mic_adc_capture #(.CLK_DIV(CD), .SAMPLE_DIV(SDB)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .adc_sdata(sdata_b),
    .adc_cs_n(cs_n_b), .adc_sclk(sclk_b), .sample(sample_b),
    .aud_rdy(aud_rdy_b), .busy(busy_b), .overrun(overrun_b)
  );

  // ADC models: MSB first, next bit after each SCLK fall
  logic [15:0] words_a[$], words_b[$];
  logic [15:0] cur_a = '0, cur_b = '0;
  int falls_a = 0, falls_b = 0;

  always @(negedge cs_n_a) begin
    cur_a = (words_a.size() > 0) ? words_a.pop_front() : 16'h0;
    falls_a = 0;
    sdata_a = cur_a[15];
  end
  always @(negedge sclk_a) if (!cs_n_a) begin
    falls_a++;
    if (falls_a <= 16) sdata_a = cur_a[16-falls_a];
  end
  always @(negedge cs_n_b) begin
    cur_b = (words_b.size() > 0) ? words_b.pop_front() : 16'h0;
    falls_b = 0;
    sdata_b = cur_b[15];
  end
  always @(negedge sclk_b) if (!cs_n_b) begin
    falls_b++;
    if (falls_b <= 16) sdata_b = cur_b[16-falls_b];
  end

  // Monitors
  logic cs_pa = 1'b1, sclk_pa = 1'b1, aud_pa = 1'b0;
  logic aud_pb = 1'b0;
  int rises_a = 0, dbl_a = 0, dbl_b = 0;
  int aq_cyc[$], aq_rise[$], csf_a[$];
  logic [11:0] aq_smp[$];
  int bq_cyc[$];
  logic [11:0] bq_smp[$];

  always @(negedge clk) begin
    if (rst) begin
      rises_a = 0;
    end else begin
      if (!cs_n_a && sclk_a && !sclk_pa) rises_a++;
      if (cs_pa && !cs_n_a) csf_a.push_back(cyc);
      if (aud_rdy_a) begin
        aq_cyc.push_back(cyc);
        aq_smp.push_back(sample_a);
        aq_rise.push_back(rises_a);
        rises_a = 0;
      end
      if (aud_rdy_a && aud_pa) dbl_a++;
      if (aud_rdy_b) begin
        bq_cyc.push_back(cyc);
        bq_smp.push_back(sample_b);
      end
      if (aud_rdy_b && aud_pb) dbl_b++;
    end
    cs_pa = cs_n_a;
    sclk_pa = sclk_a;
    aud_pa = aud_rdy_a;
    aud_pb = aud_rdy_b;
  end

  int nvec = 0, nerr = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_aq(int n, int lim);
    int k = 0;
    while (aq_cyc.size() < n && k < lim) begin
      step();
      k++;
    end
  endtask

  task automatic wait_csf(int lim);
    int k = 0;
    while (csf_a.size() == 0 && k < lim) begin
      step();
      k++;
    end
  endtask

  task automatic clear_a();
    aq_cyc.delete();
    aq_smp.delete();
    aq_rise.delete();
    csf_a.delete();
  endtask

  typedef struct {
    logic [15:0] word;
    logic [11:0] exp_smp;
  } vec_t;

  vec_t tbl[6];
  int e, h, g, n, c0;
  int eq_cyc[$];
  logic [11:0] eq_smp[$];
  logic [15:0] w;

  initial begin
    tbl[0] = '{16'h0ABC, 12'hABC};
    tbl[1] = '{16'h0001, 12'h001};
    tbl[2] = '{16'h0FFF, 12'hFFF};
    tbl[3] = '{16'h0800, 12'h800};
    tbl[4] = '{16'h0000, 12'h000};
    tbl[5] = '{16'hF5A5, 12'h5A5};

    step(3);
    chk("rst_cs_n", cs_n_a, 1);
    chk("rst_sclk", sclk_a, 1);
    chk("rst_sample", sample_a, 0);
    chk("rst_aud_rdy", aud_rdy_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_overrun", overrun_a, 0);
    chk("rst_cs_n_b", cs_n_b, 1);
    rst = 1'b0;
    step(2);

    // Table vectors: steady-rate capture
    foreach (tbl[i]) words_a.push_back(tbl[i].word);
    en_a = 1'b1;
    e = cyc;
    wait_aq(6, 6 * SDA + LAT + 20);
    chk("tbl_count", aq_cyc.size(), 6);
    chk("tbl_overrun", overrun_a, 0);
    en_a = 1'b0;
    if (csf_a.size() > 0) chk("tbl_cs_fall", csf_a[0], e + SDA);
    for (int i = 0; i < 6; i++) begin
      if (i < aq_cyc.size()) begin
        chk("tbl_time", aq_cyc[i], e + SDA - 1 + LAT + i * SDA);
        chk("tbl_sample", aq_smp[i], tbl[i].exp_smp);
        chk("tbl_rises", aq_rise[i], 16);
      end
    end
    step(100);
    chk("tbl_no_extra", aq_cyc.size(), 6);
    chk("tbl_hold", sample_a, 12'h5A5);

    // Random en intervals vs. tick-arithmetic model
    clear_a();
    for (int r = 0; r < 6; r++) begin
      g = $urandom_range(1, 60);
      step(g);
      en_a = 1'b1;
      e = cyc;
      h = $urandom_range(60, 350);
      for (int t = e + SDA - 1; t <= e + h - 1; t += SDA) begin
        w = 16'($urandom);
        words_a.push_back(w);
        eq_cyc.push_back(t + LAT);
        eq_smp.push_back(w[11:0]);
      end
      step(h);
      en_a = 1'b0;
    end
    step(150);
    chk("rnd_count", aq_cyc.size(), eq_cyc.size());
    n = (aq_cyc.size() < eq_cyc.size()) ? aq_cyc.size() : eq_cyc.size();
    for (int i = 0; i < n; i++) begin
      chk("rnd_time", aq_cyc[i], eq_cyc[i]);
      chk("rnd_sample", aq_smp[i], eq_smp[i]);
    end

    // en dropped 10 cycles into a frame
    clear_a();
    words_a.delete();
    words_a.push_back(16'h0C3D);
    en_a = 1'b1;
    wait_csf(SDA + 10);
    chk("drop_cs_fell", csf_a.size(), 1);
    c0 = (csf_a.size() > 0) ? csf_a[0] : 0;
    step(10);
    en_a = 1'b0;
    step(500);
    chk("drop_frames", csf_a.size(), 1);
    chk("drop_aud_count", aq_cyc.size(), 1);
    if (aq_cyc.size() > 0) begin
      chk("drop_aud_time", aq_cyc[0], c0 + LAT - 1);
      chk("drop_sample", aq_smp[0], 12'hC3D);
    end

    // Async reset mid-frame
    clear_a();
    words_a.push_back(16'h0777);
    words_a.push_back(16'h0246);
    en_a = 1'b1;
    wait_csf(SDA + 10);
    step(20);
    chk("pre_rst_cs_n", cs_n_a, 0);
    chk("pre_rst_busy", busy_a, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cs_n", cs_n_a, 1);
    chk("arst_sclk", sclk_a, 1);
    chk("arst_sample", sample_a, 0);
    chk("arst_busy", busy_a, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    e = cyc;
    clear_a();
    wait_csf(SDA + 10);
    chk("arst_cs_fell", csf_a.size(), 1);
    if (csf_a.size() > 0) chk("arst_first_tick", csf_a[0], e + SDA);
    wait_aq(1, LAT + 10);
    chk("arst_aud", aq_cyc.size(), 1);
    if (aq_cyc.size() > 0) begin
      chk("arst_aud_time", aq_cyc[0], e + SDA - 1 + LAT);
      chk("arst_new_sample", aq_smp[0], 12'h246);
    end
    en_a = 1'b0;

    // Overrun: SAMPLE_DIV shorter than a frame
    words_b.push_back(16'h0111);
    words_b.push_back(16'h0222);
    words_b.push_back(16'h0333);
    en_b = 1'b1;
    e = cyc;
    step(78);
    chk("ovr_before", overrun_b, 0);
    step(2);
    chk("ovr_set", overrun_b, 1);
    begin
      int k = 0;
      while (bq_cyc.size() < 3 && k < 400) begin
        step();
        k++;
      end
    end
    chk("ovr_count", bq_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < bq_cyc.size()) begin
        chk("ovr_time", bq_cyc[i], e + SDB - 1 + LAT + i * 2 * SDB);
        chk("ovr_sample", bq_smp[i], 12'h111 * (i + 1));
      end
    end
    chk("ovr_sticky", overrun_b, 1);
    en_b = 1'b0;
    step(1);
    chk("ovr_clear", overrun_b, 0);
    step(80);

    chk("dbl_aud_a", dbl_a, 0);
    chk("dbl_aud_b", dbl_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
